clef_sprite_ctrl: RTL and testbench

CLEF_SPRITE_CTRL -- requirements
Module: clef_sprite_ctrl

---
 rtl/clef_pkg.sv | 15 +
 rtl/pix_delay.sv | 25 ++
 rtl/clef_sprite_ctrl.sv | 115 +++++++++++
 tb/tb_clef_sprite_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clef_pkg.sv
// rtl/clef_pkg.sv - shared state encoding and default geometry for the clef sprite controller
package clef_pkg;

  localparam int SPR_W_DEF   = 40;
  localparam int SPR_H_DEF   = 80;
  localparam int ROM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABOVE = 2'd1,
    DRAW  = 2'd2,
    BELOW = 2'd3
  } clef_state_t;

endpackage

// File: rtl/pix_delay.sv
// rtl/pix_delay.sv - fixed-depth shift register aligning per-pixel flags with the ROM read
module pix_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/clef_sprite_ctrl.sv
// rtl/clef_sprite_ctrl.sv - overlays a ROM-backed clef sprite onto a raster at a movable origin
module clef_sprite_ctrl
  import clef_pkg::*;
#(
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [9:0]  origin_x,
  input  logic [9:0]  origin_y,
  input  logic        origin_load,
  output logic [11:0] rom_addr,
  input  logic        rom_data,
  output logic        clef_pix,
  output logic        clef_valid
);

  localparam logic [10:0] W11     = 11'(SPR_W);
  localparam logic [10:0] H11     = 11'(SPR_H);
  localparam logic [11:0] W12     = 12'(SPR_W);
  localparam logic [11:0] ROW_MAX = 12'((SPR_H - 1) * SPR_W);

  clef_state_t state, state_nx, cur;
  logic [9:0]  ox, oy, px, py;
  logic        pend;
  logic [9:0]  new_x, new_y, eff_ox, eff_oy;
  logic [9:0]  last_v;
  logic [11:0] row_base, row_eff, addr_nx;
  logic [10:0] bottom;
  logic        enter_draw, leave_draw, in_x;
  logic        hit, row_step;
  logic        hit_dn;

  // A frame_start cycle already behaves as if the new frame and its origin were in force.
  assign new_x  = origin_load ? origin_x : (pend ? px : ox);
  assign new_y  = origin_load ? origin_y : (pend ? py : oy);
  assign eff_ox = frame_start ? new_x : ox;
  assign eff_oy = frame_start ? new_y : oy;
  assign cur    = frame_start ? ABOVE : state;
  assign bottom = {1'b0, eff_oy} + H11;

  assign enter_draw = (cur == ABOVE) && pix_valid && (vcount == eff_oy);
  assign leave_draw = (cur == DRAW) && pix_valid && ({1'b0, vcount} == bottom);
  assign in_x       = ({1'b0, hcount} >= {1'b0, eff_ox}) &&
                      ({1'b0, hcount} <  ({1'b0, eff_ox} + W11));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = cur;
    if (enter_draw)      state_nx = DRAW;
    else if (leave_draw) state_nx = BELOW;
  end

  // Row base saturates on the last sprite row so a raster overrun cannot run the address past the glyph.
  always_comb begin
    hit      = 1'b0;
    row_step = 1'b0;
    if (pix_valid && in_x && (enter_draw || (cur == DRAW && !leave_draw))) hit = 1'b1;
    if (cur == DRAW && pix_valid && !leave_draw && vcount != last_v && row_base < ROW_MAX)
      row_step = 1'b1;
  end

  assign row_eff = frame_start ? 12'd0 : (row_step ? row_base + W12 : row_base);
  assign addr_nx = row_eff + {2'b00, hcount - eff_ox};

  always_ff @(posedge clk) begin
    if (!reset) begin
      ox       <= '0;
      oy       <= '0;
      px       <= '0;
      py       <= '0;
      pend     <= 1'b0;
      row_base <= '0;
      last_v   <= '0;
      rom_addr <= '0;
    end else begin
      if (origin_load) begin
        px   <= origin_x;
        py   <= origin_y;
        pend <= 1'b1;
      end
      if (frame_start) begin
        ox   <= new_x;
        oy   <= new_y;
        pend <= 1'b0;
      end
      row_base <= row_eff;
      if (pix_valid) last_v <= vcount;
      if (hit) rom_addr <= addr_nx;
    end
  end

  pix_delay #(
    .DEPTH (ROM_LAT),
    .WIDTH (2)
  ) u_pix_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({hit, pix_valid}),
    .q     ({hit_dn, clef_valid})
  );

  assign clef_pix = hit_dn & rom_data;

endmodule

// File: tb/tb_clef_sprite_ctrl.sv
// tb/tb_clef_sprite_ctrl.sv - self-checking bench for clef_sprite_ctrl against a rectangle/glyph model
module tb_clef_sprite_ctrl;

  localparam int W = 40;
  localparam int H = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  hcount = '0, vcount = '0, origin_x = '0, origin_y = '0;
  logic        origin_load = 1'b0;
  logic [11:0] rom_addr;
  logic        rom_data = 1'b0;
  logic        clef_pix, clef_valid;

  always #5 clk = ~clk;

  clef_sprite_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
    .origin_load (origin_load),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .clef_pix    (clef_pix),
    .clef_valid  (clef_valid)
  );

  bit glyph [0:4095];
  always @(posedge clk) rom_data <= (rom_addr < 12'd3200) ? glyph[rom_addr] : 1'b0;

  int errors = 0;
  int checks = 0;

  int m_ox, m_oy, m_px, m_py;
  bit m_active;
  bit e1_v, e1_p;
  int e1_x, e1_y;

  int n_lit, minx, maxx, miny, maxy, max_addr, first_addr, last_addr;
  int probe_x, probe_y, probe_addr;

  task automatic model_reset();
    m_ox = 0; m_oy = 0; m_px = 0; m_py = 0;
    m_active = 0; e1_v = 0; e1_p = 0; e1_x = 0; e1_y = 0;
  endtask

  task automatic clear_stats();
    n_lit = 0; minx = 9999; maxx = -1; miny = 9999; maxy = -1;
    max_addr = 0; first_addr = -1; last_addr = -1; probe_addr = -1;
  endtask

  task automatic fill_glyph(input bit ones);
    for (int i = 0; i < 4096; i++) glyph[i] = ones ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // One raster cycle: drive, advance the model, then check this pixel's address and the pixel issued two cycles back.
  task automatic step(input bit fs, input bit pv, input int x, input int y,
                      input bit ol, input int lx, input int ly);
    bit hit;
    int a;
    frame_start = fs; pix_valid = pv; hcount = x[9:0]; vcount = y[9:0];
    origin_load = ol; origin_x = lx[9:0]; origin_y = ly[9:0];
    if (ol) begin m_px = lx; m_py = ly; end
    if (fs) begin m_ox = m_px; m_oy = m_py; m_active = 1; end
    hit = m_active && pv && x >= m_ox && x < m_ox + W && y >= m_oy && y < m_oy + H;
    a = (y - m_oy) * W + (x - m_ox);
    @(posedge clk); #1;
    checks++;
    if (clef_valid !== e1_v || clef_pix !== e1_p) begin
      errors++;
      $display("FAIL pixel (%0d,%0d): valid/pix=%b/%b expected %b/%b", e1_x, e1_y, clef_valid, clef_pix, e1_v, e1_p);
    end
    if (clef_pix === 1'b1) begin
      n_lit++;
      if (e1_x < minx) minx = e1_x;
      if (e1_x > maxx) maxx = e1_x;
      if (e1_y < miny) miny = e1_y;
      if (e1_y > maxy) maxy = e1_y;
    end
    if (hit) begin
      checks++;
      if (rom_addr !== a[11:0]) begin
        errors++;
        $display("FAIL rom_addr (%0d,%0d): got %0d expected %0d", x, y, rom_addr, a);
      end
      if (first_addr < 0) first_addr = int'(rom_addr);
      last_addr = int'(rom_addr);
      if (x == probe_x && y == probe_y) probe_addr = int'(rom_addr);
    end
    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    e1_v = pv; e1_p = hit && glyph[a & 4095]; e1_x = x; e1_y = y;
  endtask

  task automatic raster(input int y0, input int y1, input int x0, input int x1,
                        input bit fl, input int fx, input int fy,
                        input int load_row, input int lx, input int ly);
    step(1, 0, 0, 0, fl, fx, fy);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if ($urandom_range(0, 7) == 0)
          step(0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 0, 0);
        step(0, 1, x, y, (y == load_row && x == x0), lx, ly);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 0; frame_start = 0; pix_valid = 0; origin_load = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== 12'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++;
    if (clef_pix !== 1'b0) begin errors++; $display("FAIL reset_clef_pix: got %b expected 0", clef_pix); end
    checks++;
    if (clef_valid !== 1'b0) begin errors++; $display("FAIL reset_clef_valid: got %b expected 0", clef_valid); end
    reset = 1;
    model_reset();
    clear_stats();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (n_lit !== 0) begin errors++; $display("FAIL reset_no_hits: got %0d expected 0", n_lit); end
  endtask

  task automatic test_basic();
    fill_glyph(1);
    step(0, 0, 0, 0, 1, 100, 50);
    clear_stats();
    probe_x = 139; probe_y = 129;
    raster(45, 135, 95, 145, 0, 0, 0, -1, 0, 0);
    checks++;
    if (n_lit !== 3200) begin errors++; $display("FAIL basic_count: got %0d expected 3200", n_lit); end
    checks++;
    if (minx !== 100 || maxx !== 139 || miny !== 50 || maxy !== 129) begin
      errors++;
      $display("FAIL basic_box: got x %0d..%0d y %0d..%0d expected x 100..139 y 50..129", minx, maxx, miny, maxy);
    end
    checks++;
    if (first_addr !== 0) begin errors++; $display("FAIL basic_first_addr: got %0d expected 0", first_addr); end
    checks++;
    if (probe_addr !== 3199) begin errors++; $display("FAIL basic_last_addr: got %0d expected 3199", probe_addr); end
  endtask

  task automatic test_latency();
    fill_glyph(0);
    glyph[0] = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 100, 50, 0, 0, 0);
    checks++;
    if (clef_valid !== 1'b0) begin errors++; $display("FAIL latency_early: clef_valid got %b expected 0", clef_valid); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (clef_valid !== 1'b1 || clef_pix !== 1'b1) begin
      errors++;
      $display("FAIL latency_n_plus_2: valid/pix=%b/%b expected 1/1", clef_valid, clef_pix);
    end
  endtask

  task automatic test_clip();
    fill_glyph(1);
    step(0, 0, 0, 0, 1, 620, 450);
    clear_stats();
    probe_x = 620; probe_y = 451;
    raster(440, 479, 600, 639, 0, 0, 0, -1, 0, 0);
    checks++;
    if (n_lit !== 600) begin errors++; $display("FAIL clip_count: got %0d expected 600", n_lit); end
    checks++;
    if (minx !== 620 || maxx !== 639 || miny !== 450 || maxy !== 479) begin
      errors++;
      $display("FAIL clip_box: got x %0d..%0d y %0d..%0d expected x 620..639 y 450..479", minx, maxx, miny, maxy);
    end
    checks++;
    if (probe_addr !== 40) begin errors++; $display("FAIL clip_row1_addr: got %0d expected 40", probe_addr); end
    checks++;
    if (max_addr >= 3200) begin errors++; $display("FAIL clip_addr_range: got %0d expected <3200", max_addr); end
  endtask

  task automatic test_midframe_load();
    fill_glyph(1);
    step(0, 0, 0, 0, 1, 100, 50);
    clear_stats();
    raster(45, 135, 90, 145, 0, 0, 0, 70, 200, 100);
    checks++;
    if (n_lit !== 3200 || minx !== 100 || miny !== 50) begin
      errors++;
      $display("FAIL midframe_old: got count %0d at (%0d,%0d) expected 3200 at (100,50)", n_lit, minx, miny);
    end
    clear_stats();
    raster(95, 185, 195, 245, 0, 0, 0, -1, 0, 0);
    checks++;
    if (n_lit !== 3200 || minx !== 200 || miny !== 100) begin
      errors++;
      $display("FAIL midframe_new: got count %0d at (%0d,%0d) expected 3200 at (200,100)", n_lit, minx, miny);
    end
  endtask

  task automatic test_coincident_load();
    fill_glyph(1);
    clear_stats();
    raster(195, 285, 295, 345, 1, 300, 200, -1, 0, 0);
    checks++;
    if (n_lit !== 3200 || minx !== 300 || miny !== 200) begin
      errors++;
      $display("FAIL coincident: got count %0d at (%0d,%0d) expected 3200 at (300,200)", n_lit, minx, miny);
    end
  endtask

  task automatic test_reset_mid();
    fill_glyph(1);
    step(0, 0, 0, 0, 1, 100, 50);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int y = 45; y <= 60; y++)
      for (int x = 90; x <= ((y == 60) ? 120 : 145); x++) step(0, 1, x, y, 0, 0, 0);
    reset = 0; frame_start = 0; pix_valid = 1; hcount = 10'd121; vcount = 10'd60; origin_load = 0;
    @(posedge clk); #1;
    checks++;
    if (clef_pix !== 1'b0 || clef_valid !== 1'b0 || rom_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: pix/valid/addr=%b/%b/%0d expected 0/0/0", clef_pix, clef_valid, rom_addr);
    end
    reset = 1;
    model_reset();
    clear_stats();
    for (int y = 60; y <= 135; y++)
      for (int x = 90; x <= 145; x++) step(0, 1, x, y, 0, 0, 0);
    checks++;
    if (n_lit !== 0 || rom_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d hits addr %0d expected 0 hits addr 0", n_lit, rom_addr);
    end
    clear_stats();
    raster(45, 135, 90, 145, 1, 100, 50, -1, 0, 0);
    checks++;
    if (n_lit !== 3200) begin errors++; $display("FAIL reset_mid_recover: got %0d expected 3200", n_lit); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int rx, ry, y0, y1, x0, x1, exp_cnt;
      bit coinc;
      fill_glyph(0);
      rx = $urandom_range(0, 639);
      ry = $urandom_range(0, 479);
      coinc = 1'($urandom_range(0, 1));
      if (!coinc) step(0, 0, 0, 0, 1, rx, ry);
      y0 = (ry > 3) ? ry - 3 : 0;
      y1 = (ry + 84 < 479) ? ry + 84 : 479;
      x0 = (rx > 5) ? rx - 5 : 0;
      x1 = (rx + 44 < 639) ? rx + 44 : 639;
      exp_cnt = 0;
      for (int r = 0; r < H && ry + r < 480; r++)
        for (int c = 0; c < W && rx + c < 640; c++) exp_cnt += int'(glyph[r * W + c]);
      clear_stats();
      raster(y0, y1, x0, x1, coinc, rx, ry, ry + 10, $urandom_range(0, 639), $urandom_range(0, 479));
      checks++;
      if (n_lit !== exp_cnt) begin
        errors++;
        $display("FAIL random_count origin (%0d,%0d): got %0d expected %0d", rx, ry, n_lit, exp_cnt);
      end
      checks++;
      if (max_addr >= 3200) begin errors++; $display("FAIL random_addr_range: got %0d expected <3200", max_addr); end
    end
  endtask

  initial begin
    model_reset();
    clear_stats();
    probe_x = -1; probe_y = -1;
    test_reset();
    test_basic();
    test_latency();
    test_clip();
    test_midframe_load();
    test_coincident_load();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
